// File: rtl/ioctrl_sched.sv
// ioctrl_sched: per-frame refresh sequencer for the two I/O chips and arbiter of their shared I/O RAM.
// Build option: define IOCTRL_SCHED_STARVE_GUARD_EN to bound how long the CPU can starve the sequencer.
module ioctrl_sched #(
    parameter int SEQ_LEN   = 16,
    parameter int STALL_MAX = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VBLANK,
    input  logic       CPU_REQ,
    input  logic       CPU_WR,
    input  logic       CPU_CHIP,
    input  logic [5:0] CPU_ADRS,
    input  logic [3:0] CPU_DIN,
    output logic [3:0] CPU_DOUT,
    output logic       CPU_ACK,
    output logic       CPU_WAIT,
    output logic [4:0] SRC_SEL,
    input  logic [3:0] SRC_DATA,
    output logic       RAM_CS,
    output logic       RAM_WE,
    output logic       RAM_CHIP,
    output logic [5:0] RAM_ADRS,
    output logic [3:0] RAM_DIN,
    input  logic [3:0] RAM_DOUT,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] dbg_state
);

    // Handshake: CPU_REQ is held until CPU_ACK; a request still high in the
    // ACK cycle is a fresh request and is arbitrated again that cycle.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHIP0 = 2'd1,
        S_CHIP1 = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] index;
    logic       pending;
    logic       vblank_prev;
    logic       ack_q;
    logic       ack_rd_q;
    logic [3:0] dout_q;

    logic vblank_rise;
    logic seq_active;
    logic seq_chip;
    logic force_seq;
    logic cpu_grant;
    logic seq_grant;
    logic last_idx;

    assign vblank_rise = VBLANK & ~vblank_prev;
    assign seq_active  = (state == S_CHIP0) || (state == S_CHIP1);
    assign seq_chip    = (state == S_CHIP1) || (state == S_FIN);
    assign last_idx    = (index == LAST_IDX);
    assign cpu_grant   = CPU_REQ & ~force_seq;
    assign seq_grant   = seq_active & ~cpu_grant;

`ifdef IOCTRL_SCHED_STARVE_GUARD_EN
    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    logic [7:0] stall_cnt;

    assign force_seq = seq_active && (stall_cnt == STALL_LIMIT);

    // Counts consecutive cycles the active sequencer lost the slot to the CPU.
    always_ff @(posedge CLK) begin
        if (RESET || !seq_active || seq_grant) begin
            stall_cnt <= 8'd0;
        end else begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    logic unused_stall_max;

    // Strict CPU priority: STALL_MAX has no effect in this build.
    assign unused_stall_max = (STALL_MAX > 0);
    assign force_seq        = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (vblank_rise || pending) begin
                    state_nxt = S_CHIP0;
                end
            end
            S_CHIP0: begin
                if (seq_grant && last_idx) begin
                    state_nxt = S_CHIP1;
                end
            end
            S_CHIP1: begin
                if (seq_grant && last_idx) begin
                    state_nxt = S_FIN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        BUSY      = (state != S_IDLE);
        DONE      = (state == S_FIN);
        dbg_state = state;
        SRC_SEL   = BUSY ? {seq_chip, index} : 5'd0;
        CPU_WAIT  = CPU_REQ & seq_grant;
        CPU_ACK   = ack_q;
        CPU_DOUT  = ack_rd_q ? RAM_DOUT : dout_q;
        RAM_CS    = 1'b0;
        RAM_WE    = 1'b0;
        RAM_CHIP  = 1'b0;
        RAM_ADRS  = 6'd0;
        RAM_DIN   = 4'd0;
        if (cpu_grant) begin
            RAM_CS   = 1'b1;
            RAM_WE   = CPU_WR;
            RAM_CHIP = CPU_CHIP;
            RAM_ADRS = CPU_ADRS;
            RAM_DIN  = CPU_DIN;
        end else if (seq_grant) begin
            RAM_CS   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_CHIP = seq_chip;
            RAM_ADRS = {2'b00, index};
            RAM_DIN  = SRC_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            index <= 4'd0;
        end else if (state == S_IDLE) begin
            index <= 4'd0;
        end else if (seq_grant) begin
            index <= last_idx ? 4'd0 : index + 4'd1;
        end
    end

    // Only one extra pass is remembered; IDLE consumes it and launches the pass.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending     <= 1'b0;
            vblank_prev <= 1'b1;
        end else begin
            vblank_prev <= VBLANK;
            if (state == S_IDLE) begin
                pending <= 1'b0;
            end else if (vblank_rise) begin
                pending <= 1'b1;
            end
        end
    end

    // RAM read data arrives the cycle after the grant and is latched for the CPU.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ack_q    <= 1'b0;
            ack_rd_q <= 1'b0;
            dout_q   <= 4'd0;
        end else begin
            ack_q    <= cpu_grant;
            ack_rd_q <= cpu_grant & ~CPU_WR;
            if (ack_rd_q) begin
                dout_q <= RAM_DOUT;
            end
        end
    end

endmodule

// File: doc/ioctrl_sched.md
# ioctrl_sched

- Per-frame scheduler and RAM arbiter for the two custom I/O chips.
- On each VBLANK rising edge it sequences a refresh pass: it writes SEQ_LEN input nibbles into the low region (ADRS[5:4]=00) of chip 0, then of chip 1.
- It shares the single-port 64x4-per-chip I/O register RAM between that sequencer and the main-CPU port.
- Sits between the CPU bus decode, the input-mapping logic and the I/O RAM.

## Interface
Parameters:
- SEQ_LEN, 16: nibbles written per chip per pass, 1..16.
- STALL_MAX, 8: consecutive denied sequencer cycles before a forced sequencer slot, 1..255.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high.
- VBLANK  in  1  frame strobe; rising edge requests a pass.
- CPU_REQ  in  1  CPU access request; held until CPU_ACK.
- CPU_WR  in  1  1 = write.
- CPU_CHIP  in  1  target chip.
- CPU_ADRS  in  6  nibble address.
- CPU_DIN  in  4  write data.
- CPU_DOUT  out  4  read data.
- CPU_ACK  out  1  one-cycle completion strobe.
- CPU_WAIT  out  1  request pending, not granted this cycle.
- SRC_SEL  out  5  {chip, index[3:0]}, selects the input nibble.
- SRC_DATA  in  4  combinational input nibble for SRC_SEL.
- RAM_CS, RAM_WE  out  1  RAM strobes.
- RAM_CHIP  out  1  RAM chip select.
- RAM_ADRS  out  6  RAM address.
- RAM_DIN  out  4  RAM write data.
- RAM_DOUT  in  4  RAM read data, valid the cycle after RAM_CS.
- BUSY  out  1  pass in progress.
- DONE  out  1  one-cycle strobe at end of pass.

## Operation
- Sequencer states: IDLE, CHIP0, CHIP1, FIN.
  - IDLE -> CHIP0 (index=0) on a VBLANK rising edge, or when the pending flag is set.
  - In CHIP0/CHIP1, each granted slot writes RAM_CHIP=state's chip, RAM_ADRS={2'b00,index}, RAM_DIN=SRC_DATA, then increments index.
  - After index SEQ_LEN-1: CHIP0 -> CHIP1 (index=0), and CHIP1 -> FIN.
  - FIN: DONE=1 for one cycle, then IDLE.
- BUSY=1 in CHIP0, CHIP1 and FIN.
- SRC_SEL={chip,index} whenever BUSY; it is 0 otherwise.
- VBLANK edge while BUSY sets a single pending flag; further edges while pending are dropped. Pending is consumed when IDLE is entered, so a new pass starts one cycle after FIN.
- Edge detect uses a previous-VBLANK register reset to 1, so VBLANK already high at reset release does not trigger a pass.
- Arbitration, evaluated every cycle (CPU has priority):
  - CPU_REQ=1 wins the slot.
  - Otherwise an active sequencer (CHIP0/CHIP1) wins.
- The slot drives RAM_CS=1 combinationally. For a CPU slot: RAM_WE=CPU_WR, RAM_CHIP/ADRS/DIN from the CPU port.
- No slot: RAM_CS=RAM_WE=0, all RAM address/data outputs 0.
- CPU_REQ still high in the ACK cycle is a new request and is arbitrated normally.
- CPU_WAIT=1 only when CPU_REQ=1 and the slot went to the sequencer.

## Timing
- Reset values: all outputs 0; state IDLE; index, pending, stall counter and CPU_DOUT register all 0.
- RESET mid-pass aborts the pass, with no DONE.
- CPU access granted in cycle t:
  - CPU_ACK=1 in cycle t+1.
  - For a read, CPU_DOUT=RAM_DOUT during t+1 and is then held until the next read ACK.
  - Writes leave CPU_DOUT unchanged.
- Sequencer write latency is zero: data is written in its grant cycle.
- Uncontended pass length: 2*SEQ_LEN slot cycles + 1 FIN cycle. Default is 33 cycles from the cycle after the VBLANK edge until DONE inclusive.
- The CPU may be granted every cycle. Back-to-back reads produce ACK every cycle, with pipelined data.

## Configuration
- IOCTRL_SCHED_STARVE_GUARD_EN defined: an 8-bit stall counter increments on each cycle the sequencer is active but denied.
  - When it equals STALL_MAX, the next cycle is forced to the sequencer, CPU_WAIT=1 if CPU_REQ.
  - The counter clears on any sequencer grant and in IDLE.
- Undefined: strict CPU priority, no counter; the sequencer can be starved indefinitely.

## Test plan
- Reset, then VBLANK 0->1 with no CPU traffic, SRC_DATA=index: 32 RAM writes, chip0 addresses 0..15 then chip1 0..15 with data 0..15, DONE in cycle 33, BUSY then falls.
- CPU writes 0xA to chip1/addr 0x28, then reads it back: ACK one cycle after each grant, CPU_DOUT=0xA during the read ACK and held afterwards.
- VBLANK edge and CPU_REQ together with CPU_REQ held 20 cycles: with the guard (STALL_MAX=8), a sequencer slot every 9th cycle with CPU_WAIT=1 then. Without the guard, no sequencer writes until CPU_REQ drops.
- Three VBLANK edges during one pass: exactly one extra pass starts the cycle after FIN, with exactly two DONE strobes total.
- RESET asserted at pass index 5 of chip0: all outputs 0 next cycle, no DONE; VBLANK still high after reset does not start a pass.
